// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {pc, instr} pairs; the head is always read from
// registered storage, so consumers never see imem_rdata combinationally.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t wdata,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t entries [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;
  logic [1:0]   count_next;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count_next;
    end
  end

  // NOTE: the storage array is deliberately not reset; the empty-head mux below hides stale contents.
  always_ff @(posedge clk) begin
    if (do_push && !clear) entries[wr_ptr] <= wdata;
  end

  assign head = (count == 2'd0) ? '{pc: 32'h0, instr: NOP_INSTR} : entries[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, redirect handling, sticky misalignment flag,
// feeding a two-entry instruction buffer toward decode.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        imem_we,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        misalign_err
);

  logic [31:0]  pc;
  logic [1:0]   count;
  logic         full;
  logic         push;
  logic         pop;
  fetch_entry_t head;
  fetch_entry_t wdata;

  assign full        = (count == 2'(BUF_DEPTH));
  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid && instr_ready && !redirect_valid;
  // A full buffer still accepts a new word when the head leaves in the same cycle.
  assign push        = !redirect_valid && (!full || pop);

  assign imem_addr = pc;
  assign imem_we   = 1'b0;
  assign wdata     = '{pc: pc, instr: imem_rdata};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      pc <= pc + PC_STEP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_err <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      misalign_err <= 1'b1;
    end
  end

  fetch_buffer u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (redirect_valid),
    .wdata (wdata),
    .count (count),
    .head  (head)
  );

  assign instr_out = head.instr;
  assign instr_pc  = head.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; program memory returns the bitwise inverse of the address.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_we;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        misalign_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  assign imem_rdata = ~imem_addr;

  fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_we        (imem_we),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .misalign_err   (misalign_err)
  );

  // Assert reset, hold for a negedge, then release with the given ready level.
  task automatic do_reset(input logic ready);
    @(negedge clk);
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = ready;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", instr_valid); end
    checks++; if (instr_out !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr got=%h exp=00000013", instr_out); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", instr_pc); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%0b exp=0", misalign_err); end
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%0b exp=0", imem_we); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    logic [31:0] exp_in [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFF7,
                                32'hFFFF_FFF3, 32'hFFFF_FFEF, 32'hFFFF_FFEB};
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%0b exp=1", i, instr_valid); end
      checks++; if (instr_pc !== exp_pc[i]) begin errors++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, instr_pc, exp_pc[i]); end
      checks++; if (instr_out !== exp_in[i]) begin errors++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, instr_out, exp_in[i]); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc [3] = '{32'h4, 32'h8, 32'hC};
    do_reset(1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL stall_head[%0d] got=%h exp=0", k, instr_pc); end
      if (k >= 2) begin
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL stall_pc[%0d] got=%h exp=8", k, imem_addr); end
      end
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got=%0b exp=1", i, instr_valid); end
      checks++; if (instr_pc !== exp_pc[i]) begin errors++; $display("FAIL drain_pc[%0d] got=%h exp=%h", i, instr_pc, exp_pc[i]); end
    end
  endtask

  task automatic test_redirect_full();
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble got=%0b exp=0", instr_valid); end
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL redir_addr got=%h exp=40", imem_addr); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL redir_valid got=%0b exp=1", instr_valid); end
    checks++; if (instr_pc !== 32'h40) begin errors++; $display("FAIL redir_pc got=%h exp=40", instr_pc); end
    checks++; if (instr_out !== 32'hFFFF_FFBF) begin errors++; $display("FAIL redir_instr got=%h exp=ffffffbf", instr_out); end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_set got=%0b exp=1", misalign_err); end
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL mis_addr got=%h exp=40", imem_addr); end
    @(negedge clk);
    checks++; if (instr_pc !== 32'h40) begin errors++; $display("FAIL mis_pc got=%h exp=40", instr_pc); end
    // Back-to-back aligned redirects: the later target must win and the flag must stick.
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_pc = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL b2b_bubble got=%0b exp=0", instr_valid); end
    checks++; if (imem_addr !== 32'h300) begin errors++; $display("FAIL b2b_addr got=%h exp=300", imem_addr); end
    @(negedge clk);
    checks++; if (instr_pc !== 32'h300) begin errors++; $display("FAIL b2b_pc got=%h exp=300", instr_pc); end
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_sticky got=%0b exp=1", misalign_err); end
    do_reset(1'b0);
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_cleared got=%0b exp=0", misalign_err); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (instr_pc !== exp_pc[i]) begin errors++; $display("FAIL wrap_pc[%0d] got=%h exp=%h", i, instr_pc, exp_pc[i]); end
    end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL wrap_flag got=%0b exp=0", misalign_err); end
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL arst_pre got=%0b exp=1", instr_valid); end
    #2 reset = 1'b1;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%0b exp=0", instr_valid); end
    checks++; if (instr_out !== 32'h0000_0013) begin errors++; $display("FAIL arst_instr got=%h exp=00000013", instr_out); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL arst_addr got=%h exp=0", imem_addr); end
    @(negedge clk);
    reset = 1'b0; instr_ready = 1'b1;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL arst_resume_valid got=%0b exp=1", instr_valid); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL arst_resume_pc got=%h exp=0", instr_pc); end
    @(negedge clk);
    checks++; if (instr_pc !== 32'h4) begin errors++; $display("FAIL arst_next_pc got=%h exp=4", instr_pc); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_misalign();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, the instruction buffer depth in entries; only 2 is supported.
REQ-003 Port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port imem_addr, output, 32 bits: byte address to program memory (the current PC).
REQ-006 Port imem_rdata, input, 32 bits: instruction word returned combinationally for imem_addr.
REQ-007 Port imem_we, output, 1 bit: program-memory write enable, tied to 0.
REQ-008 Port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-009 Port redirect_pc, input, 32 bits: redirect target byte address.
REQ-010 Port instr_valid, output, 1 bit: the instruction at the buffer head is valid.
REQ-011 Port instr_ready, input, 1 bit: decode accepts the head entry.
REQ-012 Port instr_out, output, 32 bits: instruction word at the buffer head.
REQ-013 Port instr_pc, output, 32 bits: PC of instr_out.
REQ-014 Port misalign_err, output, 1 bit: sticky flag, set by a misaligned redirect.

Function
REQ-015 imem_addr SHALL equal the pc register combinationally.
- Memory read is zero-latency.
REQ-016 Push condition SHALL be: !redirect_valid && (count<2 || pop).
- On push: {pc, imem_rdata} is written at the tail and pc <= pc+4.
REQ-017 pop SHALL equal instr_valid && instr_ready && !redirect_valid.
- On pop: the head advances.
REQ-018 instr_valid SHALL equal (count!=0).
- instr_out and instr_pc SHALL come from the head entry, with no combinational path from imem_rdata.
REQ-019 Simultaneous push and pop SHALL keep count unchanged, including at count==2.
REQ-020 When count==2 and no pop occurs, pc SHALL hold and no push SHALL occur.
REQ-021 redirect_valid SHALL take priority over push and pop in the same cycle:
- pc <= {redirect_pc[31:2], 2'b00};
- count <= 0;
- the pointers are cleared.
REQ-022 After a redirect edge, instr_valid SHALL be 0 for exactly one cycle; the target instruction is valid on the following cycle.
REQ-023 A redirect with redirect_pc[1:0]!=0 SHALL set misalign_err, which holds until reset; the fetch still proceeds at the aligned address.
REQ-024 Back-to-back redirects SHALL each take effect; the last one wins.
REQ-025 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), with no flag.
REQ-026 The first instruction SHALL be valid on the first rising edge after reset deasserts, with instr_pc=RESET_PC.

Reset
REQ-027 While reset is high, the block SHALL hold:
- pc=RESET_PC;
- count=0 and both pointers 0;
- instr_valid=0 and misalign_err=0;
- instr_out=32'h0000_0013 (NOP) and instr_pc=0.
REQ-028 Assertion of reset mid-operation SHALL discard all buffered entries immediately, without waiting for a clock edge.

Structure
REQ-029 Package fetch_pkg SHALL hold:
- typedef fetch_entry_t {pc[31:0], instr[31:0]};
- constant NOP_INSTR=32'h0000_0013;
- constant PC_STEP=4.
REQ-030 The buffer SHALL be a sub-module fetch_buffer, a 2-entry FIFO of fetch_entry_t with push, pop, clear, count, head, and async reset.
REQ-031 fetch_stage SHALL contain the pc register, the redirect logic and the error flag; no other state.

Verification
REQ-032 Reset release with instr_ready=1 and memory words 0..5 SHALL give:
- instr_pc 0,4,8,... on consecutive cycles;
- instr_out matching each memory word.
REQ-033 Holding instr_ready=0 for 5 cycles SHALL give:
- count saturates at 2 and pc holds at 8;
- on release, instructions at 0 and 4 drain in order, then 8 follows with no gap.
REQ-034 redirect_valid with redirect_pc=32'h40 while the buffer is full SHALL give:
- the next cycle: instr_valid=0;
- the cycle after: instr_pc=32'h40 with its word.
REQ-035 redirect_pc=32'h42 SHALL give:
- misalign_err=1 with the fetch at 32'h40;
- misalign_err stays 1 across later redirects until reset.
REQ-036 Starting with pc=32'hFFFF_FFF8 via redirect SHALL give instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 Asserting reset asynchronously mid-stream with count=2 SHALL give:
- instr_valid=0 before the next edge;
- fetch resumes from RESET_PC after release.
